// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO between NUM_REQ byte-stream clients.
// A grant lasts for a whole message; a watchdog revokes grants from stalled clients.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            uart_en,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            tx_fifo_full,
    output logic                            tx_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           tx_fifo_wr_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    output logic [$clog2(NUM_REQ)-1:0]      timeout_id
);

    localparam int          IW = $clog2(NUM_REQ);
    localparam int          CW = $clog2(IDLE_TIMEOUT);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {ARB_IDLE, ARB_XFER} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gid_q, gid_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        tid_q, tid_d;
    logic                 busy_q, busy_d;
    logic                 terr_q, terr_d;
    logic [CW-1:0]        idle_q, idle_d;

    logic [IW-1:0]        pick_id;
    logic                 pick_ok;
    logic [IW-1:0]        next_id;
    logic                 own_valid;
    logic                 own_last;
    logic                 hs;

    // First valid client at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned sum;
        logic [IW-1:0] idx;
        pick_ok = 1'b0;
        pick_id = '0;
        sum     = 0;
        idx     = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            sum = int'(rr_q) + i;
            if (sum >= NR) sum = sum - NR;
            idx = IW'(sum);
            if (!pick_ok && req_valid[idx]) begin
                pick_ok = 1'b1;
                pick_id = idx;
            end
        end
    end

    always_comb begin
        own_valid = req_valid[gid_q];
        own_last  = req_last[gid_q];
        hs        = (state_q == ARB_XFER) && own_valid && !tx_fifo_full;
        next_id   = (gid_q == IW'(NR - 1)) ? '0 : gid_q + 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        gid_d           = gid_q;
        busy_d          = busy_q;
        rr_d            = rr_q;
        idle_d          = idle_q;
        terr_d          = 1'b0;
        tid_d           = tid_q;
        req_ready       = '0;
        tx_fifo_wr_en   = 1'b0;
        tx_fifo_wr_data = '0;
        case (state_q)
            ARB_IDLE: begin
                if (uart_en && pick_ok) begin
                    state_d          = ARB_XFER;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    gid_d            = pick_id;
                    busy_d           = 1'b1;
                    idle_d           = '0;
                end
            end
            ARB_XFER: begin
                req_ready[gid_q] = ~tx_fifo_full;
                tx_fifo_wr_en    = hs;
                tx_fifo_wr_data  = req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
                // Only a missing valid counts toward the watchdog; FIFO-full stalls hold the count.
                if (hs) begin
                    if (own_last) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                        busy_d  = 1'b0;
                        rr_d    = next_id;
                        idle_d  = '0;
                    end else begin
                        idle_d = '0;
                    end
                end else if (!own_valid) begin
                    if (idle_q == CW'(IDLE_TIMEOUT - 1)) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                        busy_d  = 1'b0;
                        rr_d    = next_id;
                        idle_d  = '0;
                        terr_d  = 1'b1;
                        tid_d   = gid_q;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            rr_q    <= '0;
            tid_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            tid_q   <= tid_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            idle_q  <= idle_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-client byte queues drive the clients, and a
// message-level reference model predicts every output each cycle.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              uart_en;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              tx_fifo_full;
    logic              tx_fifo_wr_en;
    logic [DW-1:0]     tx_fifo_wr_data;
    logic [N-1:0]      grant;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        timeout_id;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .uart_en(uart_en),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wr_data(tx_fifo_wr_data),
        .grant(grant), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .timeout_id(timeout_id)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pending bytes per client: bit 8 marks the last byte of a message.
    logic [8:0] q [N][$];

    int m_owner = -1;
    int m_rr    = 0;
    int m_idle  = 0;
    int m_tid   = 0;
    bit m_terr  = 1'b0;

    logic obs_terr;
    int   wr_data_log[$];
    int   wr_id_log[$];
    int   wr_cyc_log[$];
    int   cyc = 0;
    int   k_hit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = q[i][0][7:0];
                req_last[i]            = q[i][0][8];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] e_ready;
        logic [N-1:0] e_grant;
        logic         e_wr;
        logic [7:0]   e_data;
        logic         e_last;
        int           o;
        drive();
        @(negedge clock);
        e_ready = '0; e_grant = '0; e_wr = 1'b0; e_data = '0; e_last = 1'b0;
        o = m_owner;
        if (o >= 0) begin
            e_grant[o] = 1'b1;
            e_ready[o] = !tx_fifo_full;
            if (q[o].size() > 0) begin
                e_data = q[o][0][7:0];
                e_last = q[o][0][8];
                e_wr   = !tx_fifo_full;
            end
        end
        check("grant",       32'(grant),           32'(e_grant));
        check("grant_id",    32'(grant_id),        (o >= 0) ? o : 0);
        check("busy",        32'(busy),            (o >= 0) ? 1 : 0);
        check("timeout_err", 32'(timeout_err),     32'(m_terr));
        check("timeout_id",  32'(timeout_id),      m_tid);
        check("req_ready",   32'(req_ready),       32'(e_ready));
        check("wr_en",       32'(tx_fifo_wr_en),   32'(e_wr));
        check("wr_data",     32'(tx_fifo_wr_data), 32'(e_data));
        obs_terr = timeout_err;
        if (tx_fifo_wr_en === 1'b1) begin
            wr_data_log.push_back(int'(tx_fifo_wr_data));
            wr_id_log.push_back(o);
            wr_cyc_log.push_back(cyc);
        end
        @(posedge clock);
        if (reset) begin
            m_owner = -1; m_rr = 0; m_idle = 0; m_terr = 1'b0; m_tid = 0;
        end else begin
            m_terr = 1'b0;
            if (o < 0) begin
                if (uart_en) begin
                    for (int k = 0; k < N; k++) begin
                        if (q[(m_rr + k) % N].size() > 0) begin
                            m_owner = (m_rr + k) % N;
                            m_idle  = 0;
                            break;
                        end
                    end
                end
            end else if (e_wr) begin
                if (e_last) begin
                    m_rr    = (o + 1) % N;
                    m_owner = -1;
                end else begin
                    m_idle = 0;
                end
            end else if (q[o].size() == 0) begin
                if (m_idle == TO - 1) begin
                    m_terr  = 1'b1;
                    m_tid   = o;
                    m_rr    = (o + 1) % N;
                    m_owner = -1;
                end else begin
                    m_idle++;
                end
            end
        end
        if (e_wr) void'(q[o].pop_front());
        cyc++;
        #1;
    endtask

    initial begin
        reset = 1'b1; uart_en = 1'b0; tx_fifo_full = 1'b0;
        drive();
        @(posedge clock); #1;
        tick();
        check("reset_grant", 32'(grant), 0);
        reset = 1'b0; uart_en = 1'b1;

        // T1: single three-byte message from client 1
        q[1].push_back({1'b0, 8'h41}); q[1].push_back({1'b0, 8'h42}); q[1].push_back({1'b1, 8'h43});
        tick();
        check("t1_grant", 32'(grant), 32'b0010);
        wr_data_log.delete(); wr_id_log.delete(); wr_cyc_log.delete();
        tick(); tick(); tick();
        check("t1_busy_after_last", 32'(busy), 0);
        check("t1_nwrites", wr_data_log.size(), 3);
        if (wr_data_log.size() == 3) begin
            check("t1_b0", wr_data_log[0], 32'h41);
            check("t1_b1", wr_data_log[1], 32'h42);
            check("t1_b2", wr_data_log[2], 32'h43);
            check("t1_consecutive", wr_cyc_log[2] - wr_cyc_log[0], 2);
        end

        // T2: round-robin with continuous single-byte messages
        reset = 1'b1; tick(); reset = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'hA0 + i)});
        wr_data_log.delete(); wr_id_log.delete(); wr_cyc_log.delete();
        for (int t = 0; t < 12; t++) tick();
        check("t2_nwrites", wr_id_log.size(), 6);
        if (wr_id_log.size() == 6) begin
            for (int j = 0; j < 6; j++) begin
                check("t2_order", wr_id_log[j], j % N);
                if (j > 0) check("t2_bubble", wr_cyc_log[j] - wr_cyc_log[j-1], 2);
            end
        end
        for (int t = 0; t < 6; t++) tick();

        // T3: FIFO full for 20 cycles mid-message must not trip the watchdog
        for (int b = 0; b < 4; b++) q[0].push_back({(b == 3), 8'(8'h50 + b)});
        tick(); tick();
        wr_data_log.delete();
        tx_fifo_full = 1'b1;
        k_hit = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (obs_terr === 1'b1) k_hit++;
        end
        check("t3_no_timeout", k_hit, 0);
        check("t3_no_writes", wr_data_log.size(), 0);
        tx_fifo_full = 1'b0;
        tick(); tick(); tick();
        check("t3_rest_written", wr_data_log.size(), 3);
        check("t3_released", 32'(busy), 0);

        // T4: client 2 stalls after one byte; client 3 must be next
        q[2].push_back({1'b0, 8'h10});
        tick();
        check("t4_grant2", 32'(grant), 32'b0100);
        tick();
        q[3].push_back({1'b1, 8'h30}); q[0].push_back({1'b1, 8'h01});
        k_hit = 21;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (obs_terr === 1'b1) begin k_hit = k; break; end
        end
        check("t4_timeout_latency", k_hit, TO + 1);
        check("t4_timeout_id", 32'(timeout_id), 2);
        check("t4_next_grant", 32'(grant), 32'b1000);
        for (int t = 0; t < 6; t++) tick();

        // T5: uart_en drops after the first byte of a 4-byte message
        for (int b = 0; b < 4; b++) q[1].push_back({(b == 3), 8'(8'h60 + b)});
        tick(); tick();
        uart_en = 1'b0;
        q[0].push_back({1'b1, 8'h70}); q[2].push_back({1'b1, 8'h72});
        wr_data_log.delete();
        tick(); tick(); tick();
        check("t5_rest_written", wr_data_log.size(), 3);
        if (wr_data_log.size() == 3) check("t5_last_byte", wr_data_log[2], 32'h63);
        for (int t = 0; t < 5; t++) begin
            tick();
            check("t5_no_grant", 32'(grant), 0);
        end
        uart_en = 1'b1;
        tick();
        check("t5_regrant", 32'(grant), 32'b0100);
        for (int t = 0; t < 6; t++) tick();

        // T6: reset in the middle of a message
        for (int b = 0; b < 3; b++) q[1].push_back({(b == 2), 8'(8'h80 + b)});
        tick(); tick();
        q[0].push_back({1'b1, 8'h99}); q[2].push_back({1'b1, 8'h90});
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_grant_cleared", 32'(grant), 0);
        check("t6_busy_cleared", 32'(busy), 0);
        tick();
        check("t6_lowest_first", 32'(grant), 32'b0001);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset        = ($urandom_range(99) == 0);
            uart_en      = ($urandom_range(9) != 0);
            tx_fifo_full = ($urandom_range(3) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0 && q[i].size() < 6)
                    q[i].push_back({($urandom_range(2) == 0), 8'($urandom)});
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
